// File: rtl/pulse_train_sequencer_if.sv
// Command/status bundle between the front-panel/command logic (master) and the
// pulse train sequencer (slave).
interface pulse_train_sequencer_if #(
    parameter int STEPS = 4
);
    localparam int AW = $clog2(STEPS);

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [16:0]   cfg_delay;
    logic [4:0]    cfg_mlt;
    logic [AW:0]   cfg_len;
    logic [7:0]    cfg_rep;
    logic [15:0]   hold_cycles;
    logic [15:0]   gap_cycles;
    logic          start;
    logic          abort;
    logic          busy;
    logic          seq_done;
    logic [AW-1:0] step_idx;
    logic [7:0]    rep_cnt;
    logic          timeout_err;

    modport master (
        output cfg_we, cfg_addr, cfg_delay, cfg_mlt, cfg_len, cfg_rep,
               hold_cycles, gap_cycles, start, abort,
        input  busy, seq_done, step_idx, rep_cnt, timeout_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_delay, cfg_mlt, cfg_len, cfg_rep,
               hold_cycles, gap_cycles, start, abort,
        output busy, seq_done, step_idx, rep_cnt, timeout_err
    );
endinterface

// File: rtl/pulse_train_sequencer.sv
// Steps the delay generator through a programmed table of delay/multiplier
// entries, one launch handshake per step, repeated cfg_rep times.
module pulse_train_sequencer #(
    parameter int STEPS  = 4,
    parameter int SETTLE = 4,
    parameter int TMO_W  = 28
) (
    input  logic                   clk_Seq,
    input  logic                   rst_Seq_n,
    pulse_train_sequencer_if.slave ctrl,
    input  logic                   launch_PL,
    output logic [16:0]            delay,
    output logic [4:0]             dl_mlt,
    output logic                   DL_launch
);
    localparam int               AW          = $clog2(STEPS);
    localparam logic [AW:0]      LEN_MAX     = (AW+1)'(STEPS);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [TMO_W-1:0] WDOG_LAST   = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_FIRE, S_GAP, S_NEXT, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [16:0]      tbl_delay_reg [STEPS];
    logic [4:0]       tbl_mlt_reg   [STEPS];
    logic             lp_meta_reg, lp_s_reg;
    logic [AW-1:0]    step_reg, step_next;
    logic [7:0]       rep_cnt_reg, rep_cnt_next;
    logic [AW:0]      len_reg, len_next;
    logic [7:0]       rep_reg, rep_next;
    logic [15:0]      hold_reg, hold_next;
    logic [15:0]      gap_reg, gap_next;
    logic [15:0]      cnt_reg, cnt_next;
    logic [TMO_W-1:0] wdog_reg, wdog_next;
    logic             tmo_reg, tmo_next;
    logic [16:0]      delay_reg;
    logic [4:0]       mlt_reg;
    logic             load_en;
    logic [AW-1:0]    load_idx;
    logic [AW:0]      step_inc;

    assign step_inc = {1'b0, step_reg} + (AW+1)'(1);

    always_ff @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_delay_reg[i] <= '0;
                tbl_mlt_reg[i]   <= 5'd1;
            end
        end else if (ctrl.cfg_we && state_reg == S_IDLE) begin
            tbl_delay_reg[ctrl.cfg_addr] <= ctrl.cfg_delay;
            tbl_mlt_reg[ctrl.cfg_addr]   <= ctrl.cfg_mlt;
        end
    end

    // launch_PL comes from the divided-clock domain
    always_ff @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) begin
            lp_meta_reg <= 1'b0;
            lp_s_reg    <= 1'b0;
        end else begin
            lp_meta_reg <= launch_PL;
            lp_s_reg    <= lp_meta_reg;
        end
    end

    always_ff @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) state_reg <= S_IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        rep_cnt_next = rep_cnt_reg;
        len_next     = len_reg;
        rep_next     = rep_reg;
        hold_next    = hold_reg;
        gap_next     = gap_reg;
        cnt_next     = cnt_reg;
        wdog_next    = wdog_reg;
        tmo_next     = tmo_reg;
        load_en      = 1'b0;
        load_idx     = step_reg;
        if (state_reg != S_IDLE && ctrl.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (ctrl.start && !ctrl.abort && !lp_s_reg) begin
                    state_next   = S_LOAD;
                    step_next    = '0;
                    rep_cnt_next = '0;
                    tmo_next     = 1'b0;
                    cnt_next     = '0;
                    load_en      = 1'b1;
                    load_idx     = '0;
                    if (ctrl.cfg_len == '0)          len_next = (AW+1)'(1);
                    else if (ctrl.cfg_len > LEN_MAX) len_next = LEN_MAX;
                    else                             len_next = ctrl.cfg_len;
                    rep_next  = (ctrl.cfg_rep == '0)     ? 8'd1  : ctrl.cfg_rep;
                    hold_next = (ctrl.hold_cycles == '0) ? 16'd1 : ctrl.hold_cycles;
                    gap_next  = (ctrl.gap_cycles == '0)  ? 16'd1 : ctrl.gap_cycles;
                end
                S_LOAD: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        state_next = S_ARM;
                        wdog_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_ARM: begin
                    if (lp_s_reg) begin
                        state_next = S_FIRE;
                        cnt_next   = '0;
                    end else if (wdog_reg == WDOG_LAST) begin
                        // watchdog reaches all-ones on this edge
                        wdog_next  = '1;
                        tmo_next   = 1'b1;
                        state_next = S_GAP;
                        cnt_next   = '0;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (cnt_reg == hold_reg - 16'd1) begin
                        state_next = S_GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_reg >= gap_reg - 16'd1 && !lp_s_reg) begin
                        state_next = tmo_reg ? S_IDLE : S_NEXT;
                    end else if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_NEXT: begin
                    cnt_next = '0;
                    load_en  = 1'b1;
                    if (step_inc < len_reg) begin
                        step_next  = step_inc[AW-1:0];
                        load_idx   = step_inc[AW-1:0];
                        state_next = S_LOAD;
                    end else begin
                        step_next    = '0;
                        load_idx     = '0;
                        rep_cnt_next = rep_cnt_reg + 8'd1;
                        state_next   = (rep_cnt_reg + 8'd1 == rep_reg) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // delay/dl_mlt are registered on entry to LOAD so they never move while DL_launch is high
    always_ff @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) begin
            step_reg    <= '0;
            rep_cnt_reg <= '0;
            len_reg     <= '0;
            rep_reg     <= '0;
            hold_reg    <= '0;
            gap_reg     <= '0;
            cnt_reg     <= '0;
            wdog_reg    <= '0;
            tmo_reg     <= 1'b0;
            delay_reg   <= '0;
            mlt_reg     <= '0;
        end else begin
            step_reg    <= step_next;
            rep_cnt_reg <= rep_cnt_next;
            len_reg     <= len_next;
            rep_reg     <= rep_next;
            hold_reg    <= hold_next;
            gap_reg     <= gap_next;
            cnt_reg     <= cnt_next;
            wdog_reg    <= wdog_next;
            tmo_reg     <= tmo_next;
            if (load_en) begin
                delay_reg <= tbl_delay_reg[load_idx];
                mlt_reg   <= tbl_mlt_reg[load_idx];
            end
        end
    end

    assign delay            = delay_reg;
    assign dl_mlt           = mlt_reg;
    assign DL_launch        = (state_reg == S_ARM) || (state_reg == S_FIRE);
    assign ctrl.busy        = (state_reg != S_IDLE);
    assign ctrl.seq_done    = (state_reg == S_DONE);
    assign ctrl.step_idx    = step_reg;
    assign ctrl.rep_cnt     = rep_cnt_reg;
    assign ctrl.timeout_err = tmo_reg;
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Scoreboard bench for pulse_train_sequencer: a launch_PL responder models the
// delay generator, a monitor checks every DL_launch window and seq_done pulse.
module tb_pulse_train_sequencer;
    localparam int STEPS  = 4;
    localparam int SETTLE = 4;
    localparam int TMO_W  = 6;

    logic        clk_Seq   = 1'b0;
    logic        rst_Seq_n = 1'b0;
    logic        launch_PL = 1'b0;
    logic [16:0] delay;
    logic [4:0]  dl_mlt;
    logic        DL_launch;

    pulse_train_sequencer_if #(.STEPS(STEPS)) ctrl ();

    pulse_train_sequencer #(.STEPS(STEPS), .SETTLE(SETTLE), .TMO_W(TMO_W)) dut (
        .clk_Seq   (clk_Seq),
        .rst_Seq_n (rst_Seq_n),
        .ctrl      (ctrl),
        .launch_PL (launch_PL),
        .delay     (delay),
        .dl_mlt    (dl_mlt),
        .DL_launch (DL_launch)
    );

    always #5 clk_Seq = ~clk_Seq;

    typedef struct {
        int d; int m; int step; int rep; int hi; int lo;
    } arm_t;

    arm_t exp_arm[$];
    int   exp_done[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mdl_delay [STEPS];
    int   mdl_mlt   [STEPS];
    bit   lp_enable = 1'b1;
    int   lp_delay  = 12;
    int   lp_tail   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_Seq);
    endtask

    // delay generator model: raise launch_PL lp_delay cycles into DL_launch,
    // drop it lp_tail cycles after DL_launch falls
    initial begin
        int ph, cnt, tcnt;
        ph = 0; cnt = 0; tcnt = 0;
        forever begin
            @(negedge clk_Seq);
            if (!lp_enable) begin
                launch_PL = 1'b0; ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (DL_launch) begin
                    cnt++;
                    if (cnt >= lp_delay) begin
                        launch_PL = 1'b1; ph = 1; tcnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!DL_launch) begin
                if (tcnt >= lp_tail) begin
                    launch_PL = 1'b0; ph = 0; cnt = 0;
                end else begin
                    tcnt++;
                end
            end
        end
    end

    // monitor: pops one expectation per DL_launch window and per seq_done
    initial begin
        arm_t cur;
        bit   prev_dl, have_cur;
        int   hi_cnt, lo_cnt;
        prev_dl = 1'b0; have_cur = 1'b0; hi_cnt = 0; lo_cnt = 0;
        cur = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk_Seq);
            if (DL_launch && !prev_dl) begin
                hi_cnt = 0;
                if (exp_arm.size() == 0) begin
                    n_checks++; n_fail++; have_cur = 1'b0;
                    $display("FAIL unexpected_arm actual=%0d required=none", delay);
                end else begin
                    cur = exp_arm.pop_front(); have_cur = 1'b1;
                    $display("ARM step=%0d rep=%0d delay=%0d mlt=%0d", ctrl.step_idx, ctrl.rep_cnt, delay, dl_mlt);
                    chk("arm_delay", int'(delay), cur.d);
                    chk("arm_mlt", int'(dl_mlt), cur.m);
                    chk("arm_step_idx", int'(ctrl.step_idx), cur.step);
                    chk("arm_rep_cnt", int'(ctrl.rep_cnt), cur.rep);
                    if (cur.lo != 0) chk("launch_low_len", lo_cnt, cur.lo);
                end
            end
            if (!DL_launch && prev_dl) begin
                lo_cnt = 0;
                if (have_cur && cur.hi != 0) chk("launch_high_len", hi_cnt, cur.hi);
            end
            if (DL_launch) hi_cnt++;
            else           lo_cnt++;
            if (ctrl.seq_done) begin
                if (exp_done.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_seq_done actual=%0d required=none", ctrl.rep_cnt);
                end else begin
                    $display("DONE rep_cnt=%0d", ctrl.rep_cnt);
                    chk("done_rep_cnt", int'(ctrl.rep_cnt), exp_done.pop_front());
                end
            end
            prev_dl = DL_launch;
        end
    end

    task automatic write_entry(input int a, input int d, input int m);
        ctrl.cfg_we = 1'b1; ctrl.cfg_addr = 2'(a);
        ctrl.cfg_delay = 17'(d); ctrl.cfg_mlt = 5'(m);
        tick(1);
        ctrl.cfg_we = 1'b0;
        mdl_delay[a] = d; mdl_mlt[a] = m;
    endtask

    task automatic set_cfg(input int len, input int rep, input int hold, input int gap);
        ctrl.cfg_len = 3'(len); ctrl.cfg_rep = 8'(rep);
        ctrl.hold_cycles = 16'(hold); ctrl.gap_cycles = 16'(gap);
    endtask

    task automatic pulse_start();
        ctrl.start = 1'b1;
        tick(1);
        ctrl.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (!ctrl.busy) break;
            tick(1);
        end
        chk(name, int'(ctrl.busy), 0);
    endtask

    task automatic push_arm(input int s, input int r, input int hi, input int lo);
        arm_t e;
        e = '{mdl_delay[s], mdl_mlt[s], s, r, hi, lo};
        exp_arm.push_back(e);
    endtask

    task automatic run_train(input int len, input int rep, input int hold, input int gap,
                             input int lpd, input int tail);
        int el, er, eh, eg, lo;
        el = (len == 0) ? 1 : (len > STEPS) ? STEPS : len;
        er = (rep == 0) ? 1 : rep;
        eh = (hold == 0) ? 1 : hold;
        eg = (gap == 0) ? 1 : gap;
        lo = ((eg > tail + 3) ? eg : tail + 3) + 1 + SETTLE;
        for (int r = 0; r < er; r++)
            for (int s = 0; s < el; s++)
                push_arm(s, r, lpd + 2 + eh, (r == 0 && s == 0) ? 0 : lo);
        exp_done.push_back(er);
        lp_delay = lpd; lp_tail = tail;
        set_cfg(len, rep, hold, gap);
        pulse_start();
        chk("timeout_err_cleared", int'(ctrl.timeout_err), 0);
        wait_idle("train_end_busy");
        chk("rep_cnt_final", int'(ctrl.rep_cnt), er);
        tick(2);
    endtask

    initial begin
        ctrl.cfg_we = 0; ctrl.cfg_addr = '0; ctrl.cfg_delay = '0; ctrl.cfg_mlt = '0;
        ctrl.cfg_len = '0; ctrl.cfg_rep = '0; ctrl.hold_cycles = '0; ctrl.gap_cycles = '0;
        ctrl.start = 0; ctrl.abort = 0;
        for (int i = 0; i < STEPS; i++) begin mdl_delay[i] = 0; mdl_mlt[i] = 1; end
        tick(3);
        chk("rst_DL_launch", int'(DL_launch), 0);
        chk("rst_busy", int'(ctrl.busy), 0);
        chk("rst_delay", int'(delay), 0);
        chk("rst_dl_mlt", int'(dl_mlt), 0);
        chk("rst_seq_done", int'(ctrl.seq_done), 0);
        chk("rst_step_idx", int'(ctrl.step_idx), 0);
        chk("rst_rep_cnt", int'(ctrl.rep_cnt), 0);
        chk("rst_timeout_err", int'(ctrl.timeout_err), 0);
        rst_Seq_n = 1'b1;
        tick(2);

        // single step, launch_PL after 12 cycles: high = 12 + 2 + 5
        write_entry(0, 10, 1);
        run_train(1, 1, 5, 8, 12, 0);

        // three steps, two repetitions
        write_entry(0, 5, 1);
        write_entry(1, 20, 2);
        write_entry(2, 100, 1);
        run_train(3, 2, 5, 8, 12, 0);

        // launch_PL lingers 20 cycles: GAP waits for lp_s low
        run_train(2, 1, 5, 4, 6, 20);

        // len above STEPS clamps to 4 entries
        write_entry(3, 77, 3);
        run_train(7, 1, 3, 2, 3, 0);

        // zero len/rep/hold/gap behave as 1
        run_train(0, 0, 0, 0, 4, 0);

        // watchdog: ARM lasts 63 cycles, no seq_done
        lp_enable = 1'b0;
        push_arm(0, 0, (1 << TMO_W) - 1, 0);
        set_cfg(1, 1, 1, 3);
        pulse_start();
        wait_idle("tmo_busy");
        chk("tmo_flag", int'(ctrl.timeout_err), 1);
        chk("tmo_DL_launch", int'(DL_launch), 0);
        lp_enable = 1'b1;
        tick(2);
        run_train(1, 1, 2, 2, 4, 0);

        // abort during FIRE; table write while busy is dropped
        push_arm(0, 0, 0, 0);
        lp_delay = 5; lp_tail = 0;
        set_cfg(1, 1, 40, 2);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (launch_PL) break;
            tick(1);
        end
        chk("abort_lp_seen", int'(launch_PL), 1);
        ctrl.cfg_we = 1'b1; ctrl.cfg_addr = '0; ctrl.cfg_delay = 17'd999; ctrl.cfg_mlt = 5'd3;
        tick(1);
        ctrl.cfg_we = 1'b0;
        tick(3);
        chk("abort_pre_DL_launch", int'(DL_launch), 1);
        ctrl.abort = 1'b1;
        tick(1);
        ctrl.abort = 1'b0;
        chk("abort_DL_launch", int'(DL_launch), 0);
        chk("abort_busy", int'(ctrl.busy), 0);
        tick(5);
        run_train(1, 1, 2, 2, 4, 0);

        // asynchronous reset mid-ARM, table back to defaults
        lp_enable = 1'b0;
        push_arm(0, 0, 0, 0);
        set_cfg(1, 1, 1, 1);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (DL_launch) break;
            tick(1);
        end
        chk("rst_arm_seen", int'(DL_launch), 1);
        tick(3);
        #3 rst_Seq_n = 1'b0;
        #1;
        chk("arst_DL_launch", int'(DL_launch), 0);
        chk("arst_busy", int'(ctrl.busy), 0);
        chk("arst_delay", int'(delay), 0);
        chk("arst_dl_mlt", int'(dl_mlt), 0);
        tick(2);
        rst_Seq_n = 1'b1;
        for (int i = 0; i < STEPS; i++) begin mdl_delay[i] = 0; mdl_mlt[i] = 1; end
        lp_enable = 1'b1;
        tick(2);
        run_train(1, 1, 2, 2, 4, 0);

        tick(5);
        chk("arm_queue_empty", exp_arm.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_train_sequencer.md
Name: pulse_train_sequencer

Overview:
Sequencer that drives the delay generator block through a programmed train of optical sync pulses. It holds a small table of steps, each with a delay and a multiplier. For each step it loads delay/dl_mlt, raises DL_launch, waits for launch_PL, holds the pulse window, then enforces an inter-pulse gap. Sits between the front-panel/command logic and the delay generator; all of its I/O is on clk_Seq.

Parameters:
STEPS, 4, number of table entries (power of 2, 2..8)
SETTLE, 4, clk_Seq cycles between loading delay/dl_mlt and raising DL_launch (divider retune time)
TMO_W, 28, width of ARM-state watchdog counter; timeout when it reaches all-ones

Ports:
clk_Seq  in  1  system clock
rst_Seq_n  in  1  reset; asynchronous assert, active-low
cfg_we  in  1  table write strobe
cfg_addr  in  log2(STEPS)  table entry index
cfg_delay  in  17  delay value for entry
cfg_mlt  in  5  multiplier code for entry (1/2/3 valid)
cfg_len  in  log2(STEPS)+1  active steps per train
cfg_rep  in  8  train repetitions
hold_cycles  in  16  clk_Seq cycles DL_launch stays high after launch_PL seen
gap_cycles  in  16  minimum clk_Seq cycles DL_launch low between steps
start  in  1  single-cycle start request
abort  in  1  single-cycle abort
launch_PL  in  1  from delay generator (divided-clock domain, asynchronous to clk_Seq)
delay  out  17  to delay generator
dl_mlt  out  5  to delay generator
DL_launch  out  1  to delay generator
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse on normal completion
step_idx  out  log2(STEPS)  current table entry
rep_cnt  out  8  completed repetitions
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0. Table entries: delay 0, mlt 1. FSM in IDLE.
- launch_PL passes through a 2-flop synchronizer (lp_s). All decisions use lp_s.
- Table writes: accepted only in IDLE. cfg_we while busy is ignored.
- On start in IDLE, the following are latched: len, rep, hold, gap.
  - len=0 is treated as 1; len>STEPS is clamped to STEPS.
  - rep=0 is treated as 1.
  - hold=0 and gap=0 are each treated as 1.
- start is ignored when lp_s=1 in IDLE, or when not in IDLE.
- States:
  - IDLE: DL_launch=0. Leaves on start to LOAD with step_idx=0, rep_cnt=0, timeout_err cleared.
  - LOAD: delay/dl_mlt are driven from table[step_idx] from the first LOAD cycle onward. Held SETTLE cycles, then ARM.
  - ARM: DL_launch=1; the watchdog counts. lp_s=1 goes to FIRE. Watchdog all-ones sets timeout_err and goes to GAP, then IDLE without seq_done.
  - FIRE: DL_launch=1 for exactly hold cycles, then GAP.
  - GAP: DL_launch=0. Exits only when at least gap cycles have elapsed and lp_s=0. Goes to NEXT, or to IDLE if entered via timeout.
  - NEXT (1 cycle):
    - If step_idx < len-1: step_idx+1, then LOAD.
    - Else: step_idx=0 and rep_cnt+1. If rep_cnt+1 == rep, go to DONE; otherwise go to LOAD.
  - DONE (1 cycle): seq_done=1, then IDLE. rep_cnt holds its final value until the next start.
- delay/dl_mlt stay stable from LOAD through GAP. They do not change while DL_launch=1.
- abort in any non-IDLE state: next state is IDLE, DL_launch=0 the next cycle, no seq_done.
- abort and start in the same cycle in IDLE: abort wins (start ignored).
- Reset mid-train: outputs return to 0 immediately (asynchronous). The table is reinitialised.
- Timing per step:
  - DL_launch rises SETTLE cycles after entering LOAD.
  - The DL_launch low interval between steps is at least gap+1 cycles (GAP + NEXT).

Test Plan:
- Write entry0={delay=10, mlt=1}, len=1, rep=1, hold=5, gap=8, start; model launch_PL rising 12 cycles after DL_launch -> DL_launch high for (delay wait + 2 sync + 5) cycles, seq_done pulses once, rep_cnt=1, busy low afterwards.
- len=3 with entries delay 5/20/100, mlt 1/2/1, rep=2 -> delay sequence 5,20,100,5,20,100 on successive ARMs; step_idx 0,1,2,0,1,2; rep_cnt ends at 2; one seq_done.
- launch_PL stays high 20 cycles after DL_launch falls, gap=4 -> GAP held until lp_s=0, no LOAD earlier.
- launch_PL never asserted, TMO_W reduced to 6 -> timeout_err=1 after 63 ARM cycles, DL_launch drops, returns to IDLE with no seq_done; next start clears timeout_err.
- abort during FIRE -> DL_launch=0 next cycle, busy=0, no seq_done; cfg_we during run -> table unchanged after run.
- Edge configs: len=0, rep=0, hold=0, gap=0 -> single step, one repetition, 1-cycle hold, gap ≥1; rst_Seq_n pulsed low mid-ARM -> all outputs 0 asynchronously.
